iob_ibus_dbus_merge: RTL and testbench



---
 rtl/iob_ibus_dbus_merge.sv | 86 ++++++++
 tb/tb_iob_ibus_dbus_merge.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/iob_ibus_dbus_merge.sv
// rtl/iob_ibus_dbus_merge.sv - merges CPU ibus (m0) and dbus (m1) onto one memory bus (s)
// Optional macro IOB_MERGE_RR_EN selects round-robin arbitration instead of m1-first priority.
module iob_ibus_dbus_merge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;
  logic   gnt, last, winner, any_req;

  assign any_req = m0_valid || m1_valid;

  always_comb begin
    state_nxt = state;
    winner    = 1'b0;
`ifdef IOB_MERGE_RR_EN
    if (m0_valid && m1_valid) winner = ~last;
    else                      winner = m1_valid;
`else
    winner = m1_valid;
`endif
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (s_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifndef IOB_MERGE_RR_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      last    <= 1'b1;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
    end else begin
      state <= state_nxt;
      // Request is frozen here; master inputs are ignored for the rest of the transaction.
      if (state == IDLE && any_req) begin
        gnt     <= winner;
        last    <= winner;
        s_addr  <= winner ? m1_addr  : m0_addr;
        s_wdata <= winner ? m1_wdata : m0_wdata;
        s_wstrb <= winner ? m1_wstrb : m0_wstrb;
      end
    end
  end

  assign s_valid = (state == BUSY);

  // Gating with rst drops a response that lands in the same cycle as reset.
  assign m0_ready = !rst && s_valid && !gnt && s_ready;
  assign m1_ready = !rst && s_valid &&  gnt && s_ready;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_iob_ibus_dbus_merge.sv
// tb/tb_iob_ibus_dbus_merge.sv - directed table-driven bench for iob_ibus_dbus_merge
module tb_iob_ibus_dbus_merge;

  logic        clk, rst;
  logic        m0_valid, m0_ready, m1_valid, m1_ready, s_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;

  iob_ibus_dbus_merge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, m0v, m1v, sr;
    logic [31:0] m0a, m1a, m1w, srd;
    logic [3:0]  m1s;
    logic        e_sv, e_r0, e_r1;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic m0v, input logic [31:0] m0a,
    input logic m1v, input logic [31:0] m1a, input logic [31:0] m1w, input logic [3:0] m1s,
    input logic sr, input logic [31:0] srd,
    input logic e_sv, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [3:0] e_wstrb, input logic e_r0, input logic e_r1);
    vec_t v;
    v.rst = r; v.m0v = m0v; v.m0a = m0a; v.m1v = m1v; v.m1a = m1a; v.m1w = m1w; v.m1s = m1s;
    v.sr = sr; v.srd = srd; v.e_sv = e_sv; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_wstrb = e_wstrb; v.e_r0 = e_r0; v.e_r1 = e_r1;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_addr [4];
  logic        exp_gnt  [4];
  int          n;

  initial begin
    rst = 1; m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_ready = 0; s_rdata = 0;

    //            rst m0v m0a        m1v m1a        m1w        m1s  sr srd           sv addr       wdata      wstrb r0 r1
    vq.push_back(mk(1, 0, 32'h0,     0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h0,     32'h0,     4'h0, 0, 0));
    vq.push_back(mk(1, 0, 32'h0,     0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h0,     32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h0,     32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        1, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        1, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        1, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 1, 32'hCAFE0001, 1, 32'h100,   32'h0,     4'h0, 1, 0));
    // s_ready while IDLE must not produce a ready
    vq.push_back(mk(0, 0, 32'h100,   0, 32'h0,     32'h0,     4'h0, 1, 32'h77,       0, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   1, 32'h200,   32'h55,    4'hF, 0, 32'h0,        0, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   1, 32'h200,   32'h55,    4'hF, 0, 32'h0,        1, 32'h200,   32'h55,    4'hF, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   1, 32'h200,   32'h55,    4'hF, 1, 32'hDEAD,     1, 32'h200,   32'h55,    4'hF, 0, 1));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h200,   32'h55,    4'hF, 0, 32'h0,        0, 32'h200,   32'h55,    4'hF, 0, 0));
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 1, 32'h1234,     1, 32'h100,   32'h0,     4'h0, 1, 0));
    // m0 drops valid and changes addr while BUSY
    vq.push_back(mk(0, 1, 32'h100,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 0, 32'h999,   0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        1, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 0, 32'h999,   0, 32'h0,     32'h0,     4'h0, 1, 32'hBEEF,     1, 32'h100,   32'h0,     4'h0, 1, 0));
    vq.push_back(mk(0, 0, 32'h0,     0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h100,   32'h0,     4'h0, 0, 0));
    // reset during BUSY drops the in-flight response
    vq.push_back(mk(0, 0, 32'h0,     1, 32'h300,   32'h0,     4'h0, 0, 32'h0,        0, 32'h100,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(1, 0, 32'h0,     1, 32'h300,   32'h0,     4'h0, 0, 32'h0,        1, 32'h300,   32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0,     0, 32'h0,     32'h0,     4'h0, 1, 32'h42,       0, 32'h0,     32'h0,     4'h0, 0, 0));
    vq.push_back(mk(0, 0, 32'h0,     0, 32'h0,     32'h0,     4'h0, 0, 32'h0,        0, 32'h0,     32'h0,     4'h0, 0, 0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; m0_valid = vq[i].m0v; m0_addr = vq[i].m0a;
      m1_valid = vq[i].m1v; m1_addr = vq[i].m1a; m1_wdata = vq[i].m1w; m1_wstrb = vq[i].m1s;
      s_ready = vq[i].sr; s_rdata = vq[i].srd;
      #1;
      chk($sformatf("row%0d s_valid", i), {31'b0, s_valid}, {31'b0, vq[i].e_sv});
      chk($sformatf("row%0d s_addr", i), s_addr, vq[i].e_addr);
      chk($sformatf("row%0d s_wdata", i), s_wdata, vq[i].e_wdata);
      chk($sformatf("row%0d s_wstrb", i), {28'b0, s_wstrb}, {28'b0, vq[i].e_wstrb});
      chk($sformatf("row%0d m0_ready", i), {31'b0, m0_ready}, {31'b0, vq[i].e_r0});
      chk($sformatf("row%0d m1_ready", i), {31'b0, m1_ready}, {31'b0, vq[i].e_r1});
      if (vq[i].e_r0) chk($sformatf("row%0d m0_rdata", i), m0_rdata, vq[i].srd);
      if (vq[i].e_r1) chk($sformatf("row%0d m1_rdata", i), m1_rdata, vq[i].srd);
    end

    // Both masters valid continuously for four transactions after reset (last=1).
`ifdef IOB_MERGE_RR_EN
    exp_gnt[0] = 0; exp_gnt[1] = 1; exp_gnt[2] = 0; exp_gnt[3] = 1;
`else
    exp_gnt[0] = 1; exp_gnt[1] = 1; exp_gnt[2] = 1; exp_gnt[3] = 1;
`endif
    for (int k = 0; k < 4; k++) exp_addr[k] = exp_gnt[k] ? 32'h200 : 32'h100;

    @(negedge clk); rst = 1; s_ready = 0; m0_valid = 0; m1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    m0_valid = 1; m0_addr = 32'h100;
    m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'h55; m1_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk); #1; n++;
      end while (!s_valid && n < 10);
      chk($sformatf("txn%0d s_valid timeout", k), {31'b0, s_valid}, 32'd1);
      chk($sformatf("txn%0d s_addr", k), s_addr, exp_addr[k]);
      s_ready = 1; s_rdata = 32'hA000 + k; #1;
      chk($sformatf("txn%0d m0_ready", k), {31'b0, m0_ready}, {31'b0, !exp_gnt[k]});
      chk($sformatf("txn%0d m1_ready", k), {31'b0, m1_ready}, {31'b0, exp_gnt[k]});
      @(negedge clk); s_ready = 0; #1;
      chk($sformatf("txn%0d idle after ready", k), {31'b0, s_valid}, 32'd0);
    end
    m0_valid = 0; m1_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
